// File: rtl/rv_mem_pkg.sv
// rtl/rv_mem_pkg.sv - shared widths and loader FSM state encodings
package rv_mem_pkg;

  // Instruction word width and default word-address width of the instruction memory
  localparam int INST_W     = 32;
  localparam int ADDR_W_DEF = 8;

  // Loader FSM state encodings (CHECK only reachable with the checksum option)
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RECV  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] CHECK = 3'd4;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - load control, byte stream and imem write bus of the loader
interface imem_loader_if #(
  parameter int ADDR_W = rv_mem_pkg::ADDR_W_DEF
);
  logic                          load_start;
  logic [ADDR_W:0]               load_len;
  logic                          in_valid;
  logic [7:0]                    in_data;
  logic                          in_ready;
  logic                          imem_we;
  logic [ADDR_W-1:0]             imem_addr;
  logic [rv_mem_pkg::INST_W-1:0] imem_wdata;
  logic                          core_hold;
  logic                          done;
  logic                          err;

  // Host / program source side
  modport master (
    output load_start, load_len, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_hold, done, err
  );

  // Loader side
  modport slave (
    input  load_start, load_len, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, core_hold, done, err
  );
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// rtl/imem_loader_byte_assembler.sv - 4-byte little-endian word assembler with byte counter
module byte_assembler
  import rv_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic [INST_W-1:0] word,
  output logic              word_valid
);

  logic [1:0]  byte_cnt;
  logic [23:0] low_bytes;

  // The fourth byte is combined directly so the word is usable in the cycle it arrives
  assign word       = {byte_data, low_bytes};
  assign word_valid = byte_valid && (byte_cnt == 2'd3);

  // Shift accepted bytes in from the top; the counter wraps to 0 after each full word
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_cnt  <= 2'd0;
      low_bytes <= 24'd0;
    end else if (byte_valid) begin
      byte_cnt  <= byte_cnt + 2'd1;
      low_bytes <= {byte_data, low_bytes[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader into instruction memory; option IMEM_LOADER_CHECKSUM_EN
module imem_loader
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]              state;
  logic [ADDR_W:0]         len_q;
  logic [ADDR_W-1:0]       index;
  logic                    we_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [INST_W-1:0]       wdata_q;
  logic                    hold_q;
  logic                    done_q;
  logic                    err_q;
  logic                    in_ready;
  logic                    accept;
  logic                    start_req;
  logic                    len_ok;
  logic                    last_word;
  logic [INST_W-1:0]       word;
  logic                    word_valid;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [INST_W-1:0]       sum_q;
`endif

  assign in_ready  = (state == RECV) || (state == CHECK);
  assign accept    = bus.in_valid && in_ready;
  assign start_req = bus.load_start && ((state == IDLE) || (state == DONE));
  assign len_ok    = (bus.load_len != '0) && (bus.load_len <= DEPTH_L);
  assign last_word = ({1'b0, index} == (len_q - 1'b1));

  assign bus.in_ready   = in_ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.core_hold  = hold_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

  // One assembler serves both the program words and the trailing checksum word
  byte_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_req && len_ok),
    .byte_valid (accept),
    .byte_data  (bus.in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // Loader FSM; write strobe is registered so it lands in the WRITE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      len_q   <= '0;
      index   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.load_start) begin
            done_q <= 1'b0;
            if (len_ok) begin
              len_q  <= bus.load_len;
              index  <= '0;
              err_q  <= 1'b0;
              hold_q <= 1'b1;
              state  <= RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
              sum_q  <= '0;
`endif
            end else begin
              err_q  <= 1'b1;
              hold_q <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        RECV: begin
          if (word_valid) begin
            we_q    <= 1'b1;
            addr_q  <= index;
            wdata_q <= word;
            state   <= WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_q + word;
`endif
          end
        end
        WRITE: begin
          if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state  <= CHECK;
`else
            state  <= DONE;
            done_q <= 1'b1;
            hold_q <= 1'b0;
`endif
          end else begin
            index <= index + 1'b1;
            state <= RECV;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (word_valid) begin
            state  <= DONE;
            hold_q <= 1'b0;
            if (word == sum_q) begin
              done_q <= 1'b1;
            end else begin
              err_q  <= 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed table-driven bench for imem_loader
module tb_imem_loader;
  import rv_mem_pkg::*;

  localparam int AW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(AW)) bus ();
  imem_loader #(.ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad = 0;

  logic [AW-1:0] wr_a[$];
  logic [31:0]   wr_d[$];

  // Log every memory write the loader issues
  always @(posedge clk) begin
    if (bus.imem_we) begin
      wr_a.push_back(bus.imem_addr);
      wr_d.push_back(bus.imem_wdata);
    end
  end

  typedef struct {
    logic [AW:0]  len;
    logic [63:0]  stream;
    int           nbytes;
    int           gap;
    int           exp_writes;
    logic [31:0]  exp_w0;
    logic [31:0]  exp_w1;
    logic [31:0]  csum;
    logic         exp_done;
    logic         exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timeout", name);
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) timeout_fail("in_ready_wait");
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic start_load(input logic [AW:0] len);
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.load_len   = len;
    @(negedge clk);
    bus.load_start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int t;
    t = 0;
    while (!(bus.done || bus.err) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) timeout_fail(name);
  endtask

  initial begin
    int rdy_bad;
    logic [7:0] b;

    vecs[0] = '{9'd2,   64'h00100093_00000013, 8, 0, 2, 32'h00000013, 32'h00100093, 32'h001000A6, 1'b1, 1'b0};
    vecs[1] = '{9'd0,   64'h0,                 0, 0, 0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1};
    vecs[2] = '{9'd257, 64'h0,                 0, 0, 0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1};
    vecs[3] = '{9'd2,   64'h00100093_00000013, 8, 3, 2, 32'h00000013, 32'h00100093, 32'h001000A6, 1'b1, 1'b0};
    vecs[4] = '{9'd1,   64'h0,                 4, 1, 1, 32'h12345678, 32'h0,        32'h12345678, 1'b1, 1'b0};
    vecs[4].stream[31:0] = 32'h12345678;

    reset = 1'b1;
    bus.load_start = 1'b0;
    bus.load_len   = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {26'd0, bus.in_ready, bus.imem_we, bus.core_hold, bus.done, bus.err, 1'b0}, 32'd0);
    chk("reset_addr", {24'd0, bus.imem_addr}, 32'd0);
    chk("reset_wdata", bus.imem_wdata, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      wr_a.delete();
      wr_d.delete();
      rdy_bad = 0;
      start_load(vecs[i].len);
      if (vecs[i].exp_done) begin
        chk($sformatf("v%0d_hold_on", i), {29'd0, bus.core_hold, bus.done, bus.err}, 32'h4);
      end else begin
        chk($sformatf("v%0d_hold_off", i), {31'd0, bus.core_hold}, 32'd0);
      end
      for (int k = 0; k < vecs[i].nbytes; k++) begin
        b = vecs[i].stream[8*k +: 8];
        send_byte(b);
        for (int g = 0; g < vecs[i].gap; g++) begin
          if (k % 4 != 3 && !bus.in_ready) rdy_bad++;
          @(negedge clk);
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (vecs[i].nbytes > 0) begin
        for (int k = 0; k < 4; k++) begin
          b = vecs[i].csum[8*k +: 8];
          send_byte(b);
        end
      end
`endif
      wait_end($sformatf("v%0d_end", i));
      @(negedge clk);
      chk($sformatf("v%0d_in_ready_recv", i), rdy_bad, 0);
      chk($sformatf("v%0d_writes", i), wr_a.size(), vecs[i].exp_writes);
      if (vecs[i].exp_writes >= 1 && wr_a.size() >= 1) begin
        chk($sformatf("v%0d_a0", i), {24'd0, wr_a[0]}, 32'd0);
        chk($sformatf("v%0d_d0", i), wr_d[0], vecs[i].exp_w0);
      end
      if (vecs[i].exp_writes >= 2 && wr_a.size() >= 2) begin
        chk($sformatf("v%0d_a1", i), {24'd0, wr_a[1]}, 32'd1);
        chk($sformatf("v%0d_d1", i), wr_d[1], vecs[i].exp_w1);
      end
      chk($sformatf("v%0d_done", i), {31'd0, bus.done}, {31'd0, vecs[i].exp_done});
      chk($sformatf("v%0d_err", i), {31'd0, bus.err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_hold_end", i), {30'd0, bus.core_hold, bus.in_ready}, 32'd0);
    end

    // load_start during RECV must be ignored
    wr_a.delete();
    wr_d.delete();
    start_load(9'd1);
    send_byte(8'hEF);
    send_byte(8'hBE);
    bus.load_start = 1'b1;
    bus.load_len   = 9'd0;
    @(negedge clk);
    bus.load_start = 1'b0;
    chk("ign_start_state", {29'd0, bus.core_hold, bus.err, bus.in_ready}, 32'h5);
    send_byte(8'hAD);
    send_byte(8'hDE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hEF);
    send_byte(8'hBE);
    send_byte(8'hAD);
    send_byte(8'hDE);
`endif
    wait_end("ign_end");
    chk("ign_writes", wr_a.size(), 1);
    if (wr_d.size() >= 1) chk("ign_d0", wr_d[0], 32'hDEADBEEF);
    chk("ign_done", {30'd0, bus.done, bus.err}, 32'h2);

    // Reset after 6 bytes of a 2-word load
    wr_a.delete();
    wr_d.delete();
    start_load(9'd2);
    for (int k = 0; k < 6; k++) begin
      b = vecs[0].stream[8*k +: 8];
      send_byte(b);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", {27'd0, bus.in_ready, bus.imem_we, bus.core_hold, bus.done, bus.err}, 32'd0);
    chk("rst_mid_addr", {24'd0, bus.imem_addr}, 32'd0);
    chk("rst_mid_wdata", bus.imem_wdata, 32'd0);
    chk("rst_mid_writes", wr_a.size(), 1);
    if (wr_a.size() >= 1) chk("rst_mid_a0", {24'd0, wr_a[0]}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum must report err without done
    start_load(9'd2);
    for (int k = 0; k < 8; k++) begin
      b = vecs[0].stream[8*k +: 8];
      send_byte(b);
    end
    send_byte(8'hA7);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h00);
    wait_end("csum_bad_end");
    chk("csum_bad", {29'd0, bus.core_hold, bus.done, bus.err}, 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
